// File: rtl/jt89_bus.sv
// jt89_bus: SN76489-style CPU write interface and register file with busy handshake and tone clock enable.
// Ports: clk/rst (async active-high), cen chip clock enable, wr_n/din CPU write,
// ready write-accept flag, clken_tone cen/16, tone0..2 periods, vol0..3 attenuation,
// ctrl3 noise control, noise_rst one-cycle pulse on any noise-control write.
module jt89_bus #(
  parameter int BUSY_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic       clken_tone,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       noise_rst
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q;
  logic        wr_q, ready_q, noise_q, noise_d, typ_q, typ_d, styp, accept;
  logic [1:0]  chan_q, chan_d, sel;
  logic [7:0]  cnt_q;
  logic [3:0]  div_q;
  logic [2:0]  ctrl3_q, ctrl3_d;
  logic [9:0]  tone_q [3];
  logic [9:0]  tone_d [3];
  logic [3:0]  vol_q [4];
  logic [3:0]  vol_d [4];
  assign accept = !wr_n && wr_q && ready_q;
  // a latch byte addresses itself; a data byte reuses the stored target
  assign sel  = din[7] ? din[6:5] : chan_q;
  assign styp = din[7] ? din[4] : typ_q;
  always_comb begin
    chan_d  = accept && din[7] ? din[6:5] : chan_q;
    typ_d   = accept && din[7] ? din[4] : typ_q;
    tone_d  = tone_q;
    vol_d   = vol_q;
    ctrl3_d = ctrl3_q;
    noise_d = 1'b0;
    if (accept) begin
      if (styp) vol_d[sel] = din[3:0];
      else if (sel == 2'd3) begin
        ctrl3_d = din[2:0];
        noise_d = 1'b1;
      end
      else if (din[7]) tone_d[sel][3:0] = din[3:0];
      else tone_d[sel][9:4] = din[5:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b1;
      chan_q  <= 2'd0;
      typ_q   <= 1'b0;
      ctrl3_q <= 3'd0;
      noise_q <= 1'b0;
      div_q   <= 4'd0;
      tone_q  <= '{default: 10'd0};
      vol_q   <= '{default: 4'hF};
    end else begin
      wr_q    <= wr_n;
      chan_q  <= chan_d;
      typ_q   <= typ_d;
      ctrl3_q <= ctrl3_d;
      noise_q <= noise_d;
      div_q   <= div_q + 4'(cen);
      tone_q  <= tone_d;
      vol_q   <= vol_d;
    end
  end
  // the cen of the accepting cycle is not counted: the counter only starts in BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          state_q <= BUSY;
          cnt_q   <= 8'(BUSY_LEN);
          ready_q <= 1'b0;
        end
        BUSY: if (cen) begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ready      = ready_q;
  assign clken_tone = cen && (&div_q);
  assign tone0      = tone_q[0];
  assign tone1      = tone_q[1];
  assign tone2      = tone_q[2];
  assign vol0       = vol_q[0];
  assign vol1       = vol_q[1];
  assign vol2       = vol_q[2];
  assign vol3       = vol_q[3];
  assign ctrl3      = ctrl3_q;
  assign noise_rst  = noise_q;
endmodule

// File: tb/tb_jt89_bus.sv
// tb_jt89_bus: directed self-checking bench for jt89_bus.
module tb_jt89_bus;
  logic       clk = 1'b0, rst = 1'b1, cen = 1'b0, wr_n = 1'b1;
  logic [7:0] din = 8'd0;
  logic       ready, clken_tone, noise_rst;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  int pass = 0, total = 0, cen_period = 0, ph = 0;
  jt89_bus dut (
    .clk(clk), .rst(rst), .cen(cen), .wr_n(wr_n), .din(din), .ready(ready),
    .clken_tone(clken_tone), .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3), .ctrl3(ctrl3), .noise_rst(noise_rst)
  );
  always #5 clk = ~clk;
  task automatic clk_step();
    @(negedge clk);
    if (cen_period != 0) begin
      ph  = (ph + 1) % cen_period;
      cen = (ph == 0);
    end
  endtask
  task automatic write(input logic [7:0] d);
    int n = 0;
    while (!ready && n < 2000) begin
      clk_step();
      n++;
    end
    total++;
    if (ready !== 1'b1) $display("FAIL write_wait ready=%b exp 1", ready); else pass++;
    din  = d;
    wr_n = 1'b0;
    clk_step();
    wr_n = 1'b1;
  endtask
  task automatic test_reset();
    #12;
    total++;
    if ({ready, tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3, noise_rst} !== {1'b1, 30'd0, 16'hFFFF, 3'd0, 1'b0})
      $display("FAIL reset_state got %b %h %h %h %h%h%h%h %h %b", ready, tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3, noise_rst);
    else pass++;
    @(negedge clk);
    rst = 1'b0;
    cen_period = 1;
    clk_step();
    total++;
    if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else pass++;
  endtask
  task automatic test_tone();
    write(8'h8A);
    total++;
    if (tone0 !== 10'h00A) $display("FAIL tone_latch got %h exp 00a", tone0); else pass++;
    write(8'h3F);
    total++;
    if ({tone0, tone1, tone2} !== {10'h3FA, 10'h0, 10'h0}) $display("FAIL tone_data got %h %h %h exp 3fa 000 000", tone0, tone1, tone2); else pass++;
  endtask
  task automatic test_vol();
    write(8'hD5);
    total++;
    if (vol2 !== 4'h5) $display("FAIL vol_latch got %h exp 5", vol2); else pass++;
    write(8'h07);
    total++;
    if ({vol2, tone2, vol0} !== {4'h7, 10'h0, 4'hF}) $display("FAIL vol_data got vol2=%h tone2=%h vol0=%h exp 7 000 f", vol2, tone2, vol0); else pass++;
  endtask
  task automatic test_noise();
    write(8'hE6);
    total++;
    if ({ctrl3, noise_rst} !== {3'b110, 1'b1}) $display("FAIL noise_latch got ctrl3=%b nr=%b exp 110 1", ctrl3, noise_rst); else pass++;
    clk_step();
    total++;
    if (noise_rst !== 1'b0) $display("FAIL noise_pulse_end got %b exp 0", noise_rst); else pass++;
    write(8'h01);
    total++;
    if ({ctrl3, noise_rst, vol3} !== {3'b001, 1'b1, 4'hF}) $display("FAIL noise_data got ctrl3=%b nr=%b vol3=%h exp 001 1 f", ctrl3, noise_rst, vol3); else pass++;
    clk_step();
    total++;
    if (noise_rst !== 1'b0) $display("FAIL noise_pulse2_end got %b exp 0", noise_rst); else pass++;
  endtask
  task automatic test_busy();
    int n = 0, k = 0;
    cen_period = 3;
    write(8'h81);
    total++;
    if ({ready, tone0} !== {1'b0, 10'h3F1}) $display("FAIL busy_start got ready=%b tone0=%h exp 0 3f1", ready, tone0); else pass++;
    din = 8'h90;
    while (!ready && k < 500) begin
      if (cen) n++;
      wr_n = (k != 10);
      clk_step();
      k++;
    end
    wr_n = 1'b1;
    total++;
    if (n !== 32) $display("FAIL busy_len got %0d exp 32", n); else pass++;
    total++;
    if ({vol0, tone0} !== {4'hF, 10'h3F1}) $display("FAIL busy_ignore got vol0=%h tone0=%h exp f 3f1", vol0, tone0); else pass++;
    total++;
    if (ready !== 1'b1) $display("FAIL busy_end got %b exp 1", ready); else pass++;
  endtask
  task automatic test_divider();
    cen_period = 0;
    @(negedge clk);
    rst = 1'b1;
    cen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      #1;
      total++;
      if (clken_tone !== (k % 16 == 0)) $display("FAIL clken_cycle%0d got %b exp %b", k, clken_tone, (k % 16 == 0)); else pass++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    cen_period = 1;
    write(8'h8A);
    while (n < 22) begin
      if (cen) n++;
      clk_step();
    end
    total++;
    if ({ready, tone0} !== {1'b0, 10'h00A}) $display("FAIL midrst_pre got ready=%b tone0=%h exp 0 00a", ready, tone0); else pass++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ready, vol0, vol1, vol2, vol3, tone0, tone1, tone2} !== {1'b1, 16'hFFFF, 30'd0})
      $display("FAIL midrst_async got ready=%b vols=%h%h%h%h tones=%h %h %h", ready, vol0, vol1, vol2, vol3, tone0, tone1, tone2);
    else pass++;
    @(negedge clk);
    rst = 1'b0;
    write(8'hD3);
    total++;
    if ({vol2, ready} !== {4'h3, 1'b0}) $display("FAIL midrst_next got vol2=%h ready=%b exp 3 0", vol2, ready); else pass++;
  endtask
  initial begin
    test_reset();
    test_tone();
    test_vol();
    test_noise();
    test_busy();
    test_divider();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/jt89_bus.md
JT89_BUS -- requirements
Module: jt89_bus

Interface
REQ-001 SHALL have parameter BUSY_LEN, default 32, meaning cen pulses that ready stays low after an accepted write (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cen  input  1  chip clock enable, one clk cycle wide per chip clock.
REQ-005 SHALL have port wr_n  input  1  write strobe, active low, level-sampled on clk.
REQ-006 SHALL have port din  input  8  CPU write data.
REQ-007 SHALL have port ready  output  1  high when a new write is accepted.
REQ-008 SHALL have port clken_tone  output  1  divided enable for tone/noise generators.
REQ-009 SHALL have ports tone0, tone1, tone2  output  10 each  tone period registers.
REQ-010 SHALL have ports vol0, vol1, vol2, vol3  output  4 each  attenuation registers, 0 loudest, 15 silent.
REQ-011 SHALL have port ctrl3  output  3  noise control register.
REQ-012 SHALL have port noise_rst  output  1  one-cycle pulse on any noise-control write.

Function
REQ-013 SHALL register wr_n into wr_q each clk; write edge = !wr_n && wr_q.
REQ-014 SHALL accept a write only on a write edge with ready=1; otherwise din ignored and no register changes.
REQ-015 SHALL, for accepted din[7]=1 (latch byte), store chan=din[6:5], typ=din[4] into the latch register.
REQ-016 SHALL, on latch byte with typ=1, load vol[chan] <= din[3:0] in the same update.
REQ-017 SHALL, on latch byte with typ=0 and chan<3, load tone[chan][3:0] <= din[3:0], upper 6 bits unchanged.
REQ-018 SHALL, on latch byte with typ=0 and chan=3, load ctrl3 <= din[2:0], din[3] ignored, pulse noise_rst.
REQ-019 SHALL, for accepted din[7]=0 (data byte), use stored chan/typ: tone (chan<3): tone[chan][9:4] <= din[5:0]; volume: vol[chan] <= din[3:0]; noise (chan=3, typ=0): ctrl3 <= din[2:0] and pulse noise_rst.
REQ-020 SHALL update registers on the clk edge after the accepted write edge (1-cycle latency); noise_rst high for exactly that one cycle.
REQ-021 SHALL implement busy FSM: IDLE (ready=1) -> BUSY on accepted write; BUSY holds 8-bit counter, decrements on each cen; BUSY -> IDLE on the cen that takes it to zero.
REQ-022 SHALL drive ready low from the cycle after the accepted write until the BUSY -> IDLE transition, i.e. exactly BUSY_LEN cen pulses.
REQ-023 SHALL, if cen coincides with the accepting cycle, not count that cen toward BUSY_LEN.
REQ-024 SHALL ignore (not queue) write edges during BUSY; a held-low wr_n across BUSY -> IDLE does not re-trigger (edge required).
REQ-025 SHALL run a 4-bit divider advancing on each cen, wrapping 15 -> 0, independent of writes.
REQ-026 SHALL assert clken_tone = cen && divider==15, combinationally from registered divider, one clk wide, once per 16 cen.
REQ-027 SHALL produce ready, register outputs and noise_rst from flops; no combinational path din/wr_n -> outputs.

Reset
REQ-028 SHALL, on rst high, asynchronously set: tone0..2=0, vol0..3=4'hF, ctrl3=0, chan=0, typ=0, ready=1, FSM=IDLE, busy counter=0, divider=0, noise_rst=0, wr_q=1.
REQ-029 SHALL abort BUSY on reset mid-operation; ready=1 immediately and the write in flight is already committed or discarded per REQ-020.
REQ-030 SHALL accept the first write edge occurring after rst release with no extra wait.

Verification
REQ-031 SHALL cover: din=8'h8A then 8'h3F (each after ready) -> tone0=10'h3FA, other tones 0.
REQ-032 SHALL cover: din=8'hD5 -> vol2=5 next cycle, then data byte 8'h07 -> vol2=7, tone2 unchanged.
REQ-033 SHALL cover: din=8'hE6 -> ctrl3=3'b110, noise_rst high one cycle; data byte 8'h01 -> ctrl3=1, second noise_rst pulse.
REQ-034 SHALL cover: write, cen every 3rd clk -> ready low exactly 32 cen pulses; second write edge during BUSY leaves all registers unchanged.
REQ-035 SHALL cover: cen held high 64 cycles from reset -> clken_tone high on cycles 16, 32, 48, 64 only.
REQ-036 SHALL cover: rst asserted at BUSY count 10 -> ready=1, vols=15, tones=0 without clk edge; next write accepted.
